// File: rtl/imm_materializer.sv
// Turns a 64-bit constant and a destination register into the shortest MOVZ/MOVK
// sequence. One instruction is emitted per valid/ready beat, in ascending halfword order.
module imm_materializer (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [63:0] ReqImm,
    input  logic [4:0]  ReqRd,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic        InstrLast,
    output logic [2:0]  InstrCount
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state_q, state_d;
    logic [63:0] imm_q;
    logic [4:0]  rd_q;
    logic [3:0]  nz_q, nz_in, above;
    logic [1:0]  hw_q, hw_first, hw_next;
    logic        first_q;
    logic        accept, advance, last;
    logic [15:0] imm16;
    logic [2:0]  popcnt;

    // Halfword mask and first emitted halfword of the incoming request.
    always_comb begin
        nz_in    = '0;
        hw_first = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            nz_in[k] = (ReqImm[16*k +: 16] != '0);
        end
        for (int unsigned k = 4; k > 0; k--) begin
            if (nz_in[k-1]) hw_first = 2'(k - 1);
        end
    end

    // Set halfwords strictly above the current one; the lowest of these is next.
    always_comb begin
        above   = '0;
        hw_next = hw_q;
        for (int unsigned k = 0; k < 4; k++) begin
            above[k] = nz_q[k] && (k > 32'(hw_q));
        end
        for (int unsigned k = 4; k > 0; k--) begin
            if (above[k-1]) hw_next = 2'(k - 1);
        end
        last = (above == '0);
    end

    assign imm16  = imm_q[{hw_q, 4'b0000} +: 16];
    assign popcnt = {2'b00, nz_q[0]} + {2'b00, nz_q[1]} + {2'b00, nz_q[2]} + {2'b00, nz_q[3]};

    always_ff @(posedge CLK) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ReqReady   = 1'b0;
        InstrValid = 1'b0;
        Instr      = '0;
        InstrLast  = 1'b0;
        InstrCount = '0;
        accept     = 1'b0;
        advance    = 1'b0;
        case (state_q)
            IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    accept  = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                InstrValid = 1'b1;
                Instr      = (first_q ? 32'hD280_0000 : 32'hF280_0000)
                           | {9'b0, hw_q, imm16, rd_q};
                InstrLast  = last;
                InstrCount = (popcnt == '0) ? 3'd1 : popcnt;
                if (InstrReady) begin
                    advance = 1'b1;
                    if (last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            imm_q   <= '0;
            rd_q    <= '0;
            nz_q    <= '0;
            hw_q    <= '0;
            first_q <= 1'b0;
        end else if (accept) begin
            imm_q   <= ReqImm;
            rd_q    <= ReqRd;
            nz_q    <= nz_in;
            hw_q    <= hw_first;
            first_q <= 1'b1;
        end else if (advance && !last) begin
            hw_q    <= hw_next;
            first_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_materializer.sv
// Directed bench for imm_materializer: table of constants with hand-encoded beats,
// plus stall and mid-sequence reset sequences.
module tb_imm_materializer;

    logic        CLK = 1'b0;
    logic        Reset, ReqValid, ReqReady, InstrValid, InstrReady, InstrLast;
    logic [63:0] ReqImm;
    logic [4:0]  ReqRd;
    logic [31:0] Instr;
    logic [2:0]  InstrCount;

    int checks = 0;
    int errors = 0;

    imm_materializer dut (
        .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqImm(ReqImm), .ReqRd(ReqRd), .InstrValid(InstrValid), .InstrReady(InstrReady),
        .Instr(Instr), .InstrLast(InstrLast), .InstrCount(InstrCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0]      imm;
        logic [4:0]       rd;
        int               nbeats;
        logic [3:0][31:0] instr;
    } vec_t;

    vec_t vec [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_req(input logic [63:0] imm, input logic [4:0] rd);
        int waited = 0;
        @(negedge CLK);
        while (!ReqReady && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        check("req_ready_wait", 64'(ReqReady), 64'd1);
        ReqValid = 1'b1;
        ReqImm   = imm;
        ReqRd    = rd;
        @(negedge CLK);
        ReqValid = 1'b0;
        ReqImm   = '0;
        ReqRd    = '0;
    endtask

    initial begin
        logic [63:0] recon;
        logic [1:0]  hw;
        logic [15:0] i16;

        vec[0] = '{64'h0, 5'd5, 1, {32'h0, 32'h0, 32'h0, 32'hD280_0005}};
        vec[1] = '{64'h0000_0000_0000_1234, 5'd3, 1, {32'h0, 32'h0, 32'h0, 32'hD282_4683}};
        vec[2] = '{64'h1234_0000_0000_5678, 5'd1, 2, {32'h0, 32'h0, 32'hF2E2_4681, 32'hD28A_CF01}};
        vec[3] = '{64'hFFFF_0000_0000_0000, 5'd0, 1, {32'h0, 32'h0, 32'h0, 32'hD2FF_FFE0}};
        vec[4] = '{64'h0001_0002_0003_0004, 5'd2, 4,
                   {32'hF2E0_0022, 32'hF2C0_0042, 32'hF2A0_0062, 32'hD280_0082}};
        vec[5] = '{64'h0000_ABCD_0000_0000, 5'd31, 1, {32'h0, 32'h0, 32'h0, 32'hD2D5_79BF}};
        vec[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 4,
                   {32'hF2FF_FFE7, 32'hF2DF_FFE7, 32'hF2BF_FFE7, 32'hD29F_FFE7}};

        Reset = 1'b1; ReqValid = 1'b0; ReqImm = '0; ReqRd = '0; InstrReady = 1'b0;
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        check("rst_reqready", 64'(ReqReady), 64'd1);
        check("rst_valid", 64'(InstrValid), 64'd0);
        check("rst_instr", 64'(Instr), 64'd0);
        check("rst_last", 64'(InstrLast), 64'd0);
        check("rst_count", 64'(InstrCount), 64'd0);

        InstrReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send_req(vec[i].imm, vec[i].rd);
            recon = '0;
            for (int b = 0; b < vec[i].nbeats; b++) begin
                check($sformatf("v%0d b%0d valid", i, b), 64'(InstrValid), 64'd1);
                check($sformatf("v%0d b%0d reqready", i, b), 64'(ReqReady), 64'd0);
                check($sformatf("v%0d b%0d instr", i, b), 64'(Instr), 64'(vec[i].instr[b]));
                check($sformatf("v%0d b%0d last", i, b), 64'(InstrLast),
                      64'(b == vec[i].nbeats - 1));
                check($sformatf("v%0d b%0d count", i, b), 64'(InstrCount), 64'(vec[i].nbeats));
                hw  = Instr[22:21];
                i16 = Instr[20:5];
                recon = recon | (64'(i16) << (16 * int'(hw)));
                @(negedge CLK);
            end
            check($sformatf("v%0d idle_valid", i), 64'(InstrValid), 64'd0);
            check($sformatf("v%0d idle_reqready", i), 64'(ReqReady), 64'd1);
            check($sformatf("v%0d idle_instr", i), 64'(Instr), 64'd0);
            check($sformatf("v%0d recon", i), recon, vec[i].imm);
        end

        // Stall: Instr holds; a pending ReqValid during EMIT is not consumed.
        InstrReady = 1'b0;
        send_req(64'hFFFF_0000_0000_0000, 5'd0);
        ReqValid = 1'b1;
        ReqImm   = 64'h5555_5555_5555_5555;
        ReqRd    = 5'd9;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("stall%0d valid", s), 64'(InstrValid), 64'd1);
            check($sformatf("stall%0d instr", s), 64'(Instr), 64'hD2FF_FFE0);
            check($sformatf("stall%0d reqready", s), 64'(ReqReady), 64'd0);
            @(negedge CLK);
        end
        check("stall_end instr", 64'(Instr), 64'hD2FF_FFE0);
        check("stall_end last", 64'(InstrLast), 64'd1);
        InstrReady = 1'b1;
        ReqValid   = 1'b0;
        @(negedge CLK);
        check("stall_done valid", 64'(InstrValid), 64'd0);
        check("stall_done reqready", 64'(ReqReady), 64'd1);

        // Reset after beat 2 abandons the sequence.
        send_req(64'h0001_0002_0003_0004, 5'd2);
        check("rstmid b0", 64'(Instr), 64'hD280_0082);
        @(negedge CLK);
        check("rstmid b1", 64'(Instr), 64'hF2A0_0062);
        @(negedge CLK);
        check("rstmid b2 pending", 64'(InstrValid), 64'd1);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        check("rstmid valid", 64'(InstrValid), 64'd0);
        check("rstmid reqready", 64'(ReqReady), 64'd1);
        check("rstmid instr", 64'(Instr), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check($sformatf("rstmid quiet%0d", c), 64'(InstrValid), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
